data_mem_sequencer: RTL and testbench

Multi-cycle access controller placed between the MEM pipeline stage and the 8-bit-wide single-port data RAM (4K x 8, asynchronous read, synchronous write). Each byte, half-word or word load/store is split into 1, 2 or 4 little-endian byte beats, and the pipeline is stalled until the access completes. Idle RAM cycles are shared with the debug unit, which gets single-byte reads at lower priority than the pipeline.

---
 rtl/data_mem_sequencer.sv | 138 +++++++++++++
 tb/tb_data_mem_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_sequencer.sv
// Splits byte/half/word pipeline loads and stores into little-endian byte beats
// on an 8-bit single-port RAM, and lends idle RAM cycles to debug byte reads.
module data_mem_sequencer #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_req_valid,
    input  logic                  i_req_write,
    input  logic [31:0]           i_req_addr,
    input  logic [31:0]           i_req_wdata,
    input  logic [1:0]            i_req_size,
    input  logic                  i_req_unsigned,
    output logic                  o_stall,
    output logic                  o_done,
    output logic [31:0]           o_rdata,
    input  logic                  i_dbg_req,
    input  logic [ADDR_WIDTH-1:0] i_dbg_addr,
    output logic                  o_dbg_ack,
    output logic [7:0]            o_dbg_data,
    output logic                  o_ram_write_enable,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [7:0]            o_ram_data,
    input  logic [7:0]            i_ram_data
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [1:0]            r_beat;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [1:0]            r_size;
    logic                  r_write;
    logic                  r_unsigned;
    logic [31:0]           r_wdata;
    logic [31:0]           r_asm;
    logic                  r_dbg_ack;
    logic [7:0]            r_dbg_data;
    logic [1:0]            w_last_beat;
    logic [31:0]           w_wshift;
    logic                  w_start;
    logic                  w_unused;

    function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                                input logic [1:0]  size,
                                                input logic        uns);
        case (size)
            2'b00:   extend_load = {{24{~uns & raw[7]}}, raw[7:0]};
            2'b01:   extend_load = {{16{~uns & raw[15]}}, raw[15:0]};
            default: extend_load = raw;
        endcase
    endfunction

    assign w_unused    = ^i_req_addr[31:ADDR_WIDTH];
    assign w_start     = (r_state == S_IDLE) && i_req_valid;
    assign w_last_beat = (r_size == 2'b00) ? 2'd0 : (r_size == 2'b01) ? 2'd1 : 2'd3;
    assign w_wshift    = r_wdata >> {r_beat, 3'b000};
    assign o_dbg_ack   = r_dbg_ack;
    assign o_dbg_data  = r_dbg_data;

    always_comb begin
        w_next             = r_state;
        o_stall            = 1'b0;
        o_done             = 1'b0;
        o_rdata            = '0;
        o_ram_write_enable = 1'b0;
        o_ram_addr         = '0;
        o_ram_data         = '0;
        case (r_state)
            S_IDLE: begin
                o_stall    = i_req_valid;
                o_ram_addr = i_dbg_addr;
                if (i_req_valid)
                    w_next = S_ACCESS;
            end
            S_ACCESS: begin
                o_stall    = 1'b1;
                o_ram_addr = r_addr + ADDR_WIDTH'(r_beat);
                if (r_write) begin
                    // A reset arriving mid-store must not let the current beat land.
                    o_ram_write_enable = ~i_reset;
                    o_ram_data         = w_wshift[7:0];
                end
                if (r_beat == w_last_beat)
                    w_next = S_DONE;
            end
            S_DONE: begin
                o_done  = 1'b1;
                o_rdata = r_write ? 32'd0 : extend_load(r_asm, r_size, r_unsigned);
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_beat     <= 2'd0;
            r_dbg_ack  <= 1'b0;
            r_dbg_data <= 8'd0;
        end else begin
            r_state   <= w_next;
            r_dbg_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_beat <= 2'd0;
                    if (!i_req_valid && i_dbg_req) begin
                        r_dbg_ack  <= 1'b1;
                        r_dbg_data <= i_ram_data;
                    end
                end
                S_ACCESS: r_beat <= r_beat + 2'd1;
                default:  r_beat <= 2'd0;
            endcase
        end
    end

    // Request capture and load assembly: pure data, no reset needed.
    always_ff @(posedge i_clk) begin
        if (w_start) begin
            r_addr     <= i_req_addr[ADDR_WIDTH-1:0];
            r_size     <= i_req_size;
            r_write    <= i_req_write;
            r_unsigned <= i_req_unsigned;
            r_wdata    <= i_req_wdata;
            r_asm      <= '0;
        end else if (r_state == S_ACCESS && !r_write) begin
            r_asm <= r_asm | ({24'd0, i_ram_data} << {r_beat, 3'b000});
        end
    end

endmodule

// File: tb/tb_data_mem_sequencer.sv
// Directed bench for data_mem_sequencer: a transaction-level memory model predicts
// every cycle's outputs; literal values pin the model on key vectors.
module tb_data_mem_sequencer;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        i_req_write = 1'b0;
    logic [31:0] i_req_addr = '0;
    logic [31:0] i_req_wdata = '0;
    logic [1:0]  i_req_size = '0;
    logic        i_req_unsigned = 1'b0;
    logic        o_stall, o_done, o_dbg_ack, o_ram_write_enable;
    logic [31:0] o_rdata;
    logic        i_dbg_req = 1'b0;
    logic [11:0] i_dbg_addr = '0;
    logic [7:0]  o_dbg_data, o_ram_data, i_ram_data;
    logic [11:0] o_ram_addr;

    logic [7:0]  tb_ram  [0:4095];
    logic [7:0]  ref_mem [0:4095];

    int checks = 0;
    int failures = 0;

    logic        chk_en = 1'b0;
    logic        exp_stall, exp_done, exp_we, exp_ack;
    logic [31:0] exp_rdata;
    logic [11:0] exp_addr;
    logic [7:0]  exp_wdata;
    logic [7:0]  exp_dbg_data = '0;
    logic        lit_en = 1'b0;
    logic        lit_dbg = 1'b0;
    logic [31:0] lit_val = '0;
    logic        ram_en = 1'b0;
    logic [11:0] ram_a = '0;
    logic [7:0]  ram_lit = '0;

    always #5 clk = ~clk;

    data_mem_sequencer #(.ADDR_WIDTH(12)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_req_valid(i_req_valid), .i_req_write(i_req_write),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned),
        .o_stall(o_stall), .o_done(o_done), .o_rdata(o_rdata),
        .i_dbg_req(i_dbg_req), .i_dbg_addr(i_dbg_addr),
        .o_dbg_ack(o_dbg_ack), .o_dbg_data(o_dbg_data),
        .o_ram_write_enable(o_ram_write_enable), .o_ram_addr(o_ram_addr),
        .o_ram_data(o_ram_data), .i_ram_data(i_ram_data)
    );

    // 4K x 8 RAM: asynchronous read, synchronous write.
    assign i_ram_data = tb_ram[o_ram_addr];
    always @(posedge clk)
        if (o_ram_write_enable) tb_ram[o_ram_addr] <= o_ram_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", 32'(o_stall), 32'(exp_stall));
            check("done", 32'(o_done), 32'(exp_done));
            check("rdata", o_rdata, exp_rdata);
            check("ram_we", 32'(o_ram_write_enable), 32'(exp_we));
            check("ram_addr", 32'(o_ram_addr), 32'(exp_addr));
            check("ram_wdata", 32'(o_ram_data), 32'(exp_wdata));
            check("dbg_ack", 32'(o_dbg_ack), 32'(exp_ack));
            check("dbg_data", 32'(o_dbg_data), 32'(exp_dbg_data));
            if (lit_en && !lit_dbg) check("lit_rdata", o_rdata, lit_val);
            if (lit_en && lit_dbg)  check("lit_dbg_data", 32'(o_dbg_data), lit_val);
            if (ram_en) begin
                check("ram_vs_model", 32'(tb_ram[ram_a]), 32'(ref_mem[ram_a]));
                check("ram_literal", 32'(tb_ram[ram_a]), 32'(ram_lit));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_idle();
        exp_stall = i_req_valid;
        exp_done  = 1'b0;
        exp_rdata = '0;
        exp_we    = 1'b0;
        exp_addr  = i_dbg_addr;
        exp_wdata = '0;
        exp_ack   = 1'b0;
    endtask

    function automatic logic [31:0] model_load(input logic [11:0] a, input int n, input logic uns);
        longint v = 0;
        for (int k = 0; k < n; k++)
            v += longint'(ref_mem[(int'(a) + k) % 4096]) << (8 * k);
        if (!uns && v >= (64'sd1 << (8 * n - 1)))
            v -= (64'sd1 << (8 * n));
        return 32'(v);
    endfunction

    task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] sz, input logic uns, input logic keep,
                          input logic lit_on, input logic [31:0] lit);
        int n;
        int idx;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        i_req_valid = 1'b1; i_req_write = wr; i_req_addr = a;
        i_req_wdata = wd; i_req_size = sz; i_req_unsigned = uns;
        exp_idle();
        step();
        for (int k = 0; k < n; k++) begin
            idx = (int'(a[11:0]) + k) % 4096;
            exp_stall = 1'b1; exp_done = 1'b0; exp_rdata = '0; exp_ack = 1'b0;
            exp_we    = wr;
            exp_addr  = 12'(idx);
            exp_wdata = wr ? 8'(wd >> (8 * k)) : 8'd0;
            step();
            if (wr) ref_mem[idx] = wd[8*k +: 8];
        end
        exp_stall = 1'b0; exp_done = 1'b1;
        exp_rdata = wr ? 32'd0 : model_load(a[11:0], n, uns);
        exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; exp_ack = 1'b0;
        lit_en = lit_on; lit_dbg = 1'b0; lit_val = lit;
        if (!keep) i_req_valid = 1'b0;
        step();
        lit_en = 1'b0;
    endtask

    task automatic dbg_serve(input logic [7:0] lit);
        exp_idle();
        step();
        i_dbg_req = 1'b0;
        exp_idle();
        exp_ack = 1'b1;
        exp_dbg_data = ref_mem[i_dbg_addr];
        lit_en = 1'b1; lit_dbg = 1'b1; lit_val = 32'(lit);
        step();
        lit_en = 1'b0; lit_dbg = 1'b0;
    endtask

    task automatic ram_chk(input logic [11:0] a, input logic [7:0] lit);
        ram_en = 1'b1; ram_a = a; ram_lit = lit;
        exp_idle();
        step();
        ram_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        i_reset = 1'b0;
        chk_en = 1'b1;
        exp_idle();
        exp_dbg_data = 8'd0;
        step();

        access(1'b1, 32'h010, 32'hDEADBEEF, 2'b11, 1'b0, 1'b0, 1'b1, 32'h0);
        access(1'b0, 32'h010, 32'h0, 2'b11, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
        access(1'b0, 32'h010, 32'h0, 2'b10, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF);

        access(1'b1, 32'h020, 32'h00000080, 2'b00, 1'b0, 1'b0, 1'b1, 32'h0);
        access(1'b0, 32'h020, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1, 32'hFFFFFF80);
        access(1'b0, 32'h020, 32'h0, 2'b00, 1'b1, 1'b0, 1'b1, 32'h00000080);

        access(1'b1, 32'hFFFF_FFFF, 32'h00001234, 2'b01, 1'b0, 1'b0, 1'b1, 32'h0);
        access(1'b0, 32'h0FFF, 32'h0, 2'b01, 1'b0, 1'b0, 1'b1, 32'h00001234);
        access(1'b1, 32'h030, 32'h00008001, 2'b01, 1'b0, 1'b0, 1'b1, 32'h0);
        access(1'b0, 32'h030, 32'h0, 2'b01, 1'b0, 1'b0, 1'b1, 32'hFFFF8001);
        access(1'b0, 32'h030, 32'h0, 2'b01, 1'b1, 1'b0, 1'b1, 32'h00008001);

        // Debug request raised together with a load: the load goes first.
        i_dbg_req = 1'b1; i_dbg_addr = 12'h010;
        access(1'b0, 32'h010, 32'h0, 2'b11, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
        dbg_serve(8'hEF);
        exp_idle();
        step();

        // Reset during beat 2 of a word store.
        access(1'b1, 32'h040, 32'hAABBCCDD, 2'b11, 1'b0, 1'b0, 1'b1, 32'h0);
        i_req_valid = 1'b1; i_req_write = 1'b1; i_req_addr = 32'h040;
        i_req_wdata = 32'h11223344; i_req_size = 2'b11;
        exp_idle();
        step();
        for (int k = 0; k < 2; k++) begin
            exp_stall = 1'b1; exp_done = 1'b0; exp_rdata = '0; exp_ack = 1'b0;
            exp_we = 1'b1; exp_addr = 12'(12'h040 + k); exp_wdata = 8'(32'h11223344 >> (8 * k));
            step();
            ref_mem[12'h040 + k] = 8'(32'h11223344 >> (8 * k));
        end
        i_reset = 1'b1; i_req_valid = 1'b0;
        exp_stall = 1'b1; exp_done = 1'b0; exp_rdata = '0; exp_ack = 1'b0;
        exp_we = 1'b0; exp_addr = 12'h042; exp_wdata = 8'h22;
        step();
        i_reset = 1'b0; i_dbg_addr = 12'h000;
        exp_idle();
        exp_dbg_data = 8'd0;
        step();

        i_dbg_req = 1'b1; i_dbg_addr = 12'h041;
        dbg_serve(8'h33);

        // Back-to-back stores with valid held across DONE.
        access(1'b1, 32'h100, 32'h00005566, 2'b01, 1'b0, 1'b1, 1'b1, 32'h0);
        access(1'b1, 32'h102, 32'h00000077, 2'b00, 1'b0, 1'b0, 1'b1, 32'h0);
        access(1'b0, 32'h101, 32'h0, 2'b01, 1'b1, 1'b0, 1'b1, 32'h00007755);

        ram_chk(12'h010, 8'hEF);
        ram_chk(12'h011, 8'hBE);
        ram_chk(12'h012, 8'hAD);
        ram_chk(12'h013, 8'hDE);
        ram_chk(12'hFFF, 8'h34);
        ram_chk(12'h000, 8'h12);
        ram_chk(12'h040, 8'h44);
        ram_chk(12'h041, 8'h33);
        ram_chk(12'h042, 8'hBB);
        ram_chk(12'h043, 8'hAA);
        ram_chk(12'h100, 8'h66);
        ram_chk(12'h102, 8'h77);

        chk_en = 1'b0;
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
